// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC bus-cycle generator: FSM states, bus idle
// levels and the default phase length.
package rtc_bus_pkg;

    localparam int unsigned PHASE_CYCLES_DEF = 10;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        ADDR_SETUP  = 4'd1,
        ADDR_STROBE = 4'd2,
        ADDR_HOLD   = 4'd3,
        GAP         = 4'd4,
        DATA_SETUP  = 4'd5,
        DATA_STROBE = 4'd6,
        DATA_HOLD   = 4'd7,
        DONE        = 4'd8
    } rtc_state_e;

    localparam logic CS_N_IDLE = 1'b1;
    localparam logic RD_N_IDLE = 1'b1;
    localparam logic WR_N_IDLE = 1'b1;
    localparam logic AD_IDLE   = 1'b1;

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Decoder-side request/response and RTC multiplexed-bus signals.
// master = port decoder plus bus pins, slave = the cycle generator.
interface rtc_bus_ctrl_if;
    logic       act_rtc;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] dir;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       rtc_cs_n;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic       rtc_ad;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output act_rtc, write_strobe, read_strobe, dir, data_in, ad_in,
        input  data_out, busy, done, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad,
               ad_out, ad_oe
    );

    modport slave (
        input  act_rtc, write_strobe, read_strobe, dir, data_in, ad_in,
        output data_out, busy, done, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad,
               ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter: load sets PHASE_CYCLES-1, then counts to zero and
// holds; tc_o flags the last cycle of a phase.
module rtc_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = PHASE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic tc_o
);
    localparam int unsigned   CW       = $clog2(PHASE_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = CW'(0);

    logic [CW-1:0] count_q, count_d;

    // Next count: reload on state entry, otherwise decrement and saturate at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (count_q != ZERO) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == ZERO);
endmodule

// File: rtl/rtc_bus_ctrl.sv
// Replays PicoBlaze RTC port accesses as timed two-phase (address, then data)
// cycles on the RTC multiplexed bus. All outputs are registered.
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = PHASE_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    rtc_bus_ctrl_if.slave bus
);
    rtc_state_e state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] dir_q, dir_d, wdata_q, wdata_d, dout_q, dout_d, ad_out_q, ad_out_d;
    logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic       rtc_ad_q, rtc_ad_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic       accept_s, tc_s, load_s;

    assign accept_s = (state_q == IDLE) && bus.act_rtc && (bus.write_strobe || bus.read_strobe);
    assign load_s   = (state_d != state_q);

    rtc_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (load_s),
        .tc_o   (tc_s)
    );

    // Next-state logic; strobes outside IDLE are simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = accept_s ? ADDR_SETUP  : IDLE;
            ADDR_SETUP:  state_d = tc_s     ? ADDR_STROBE : ADDR_SETUP;
            ADDR_STROBE: state_d = tc_s     ? ADDR_HOLD   : ADDR_STROBE;
            ADDR_HOLD:   state_d = tc_s     ? GAP         : ADDR_HOLD;
            GAP:         state_d = tc_s     ? DATA_SETUP  : GAP;
            DATA_SETUP:  state_d = tc_s     ? DATA_STROBE : DATA_SETUP;
            DATA_STROBE: state_d = tc_s     ? DATA_HOLD   : DATA_STROBE;
            DATA_HOLD:   state_d = tc_s     ? DONE        : DATA_HOLD;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Request capture on accept (write wins when both strobes are high) and read-data capture.
    always_comb begin
        is_wr_d = accept_s ? bus.write_strobe : is_wr_q;
        dir_d   = accept_s ? bus.dir          : dir_q;
        wdata_d = accept_s ? bus.data_in      : wdata_q;
        dout_d  = ((state_q == DATA_STROBE) && tc_s && !is_wr_q) ? bus.ad_in : dout_q;
    end

    // Bus outputs decoded from the state being entered so they change on state entry.
    always_comb begin
        cs_n_d   = CS_N_IDLE;
        rd_n_d   = RD_N_IDLE;
        wr_n_d   = WR_N_IDLE;
        rtc_ad_d = AD_IDLE;
        oe_d     = 1'b0;
        ad_out_d = 8'h00;
        case (state_d)
            ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
                cs_n_d   = 1'b0;
                rtc_ad_d = 1'b0;
                oe_d     = 1'b1;
                ad_out_d = dir_d;
                wr_n_d   = (state_d == ADDR_STROBE) ? 1'b0 : 1'b1;
            end
            DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
                cs_n_d   = 1'b0;
                rtc_ad_d = 1'b1;
                oe_d     = is_wr_d;
                ad_out_d = is_wr_d ? wdata_d : 8'h00;
                wr_n_d   = ((state_d == DATA_STROBE) && is_wr_d)  ? 1'b0 : 1'b1;
                rd_n_d   = ((state_d == DATA_STROBE) && !is_wr_d) ? 1'b0 : 1'b1;
            end
            default: begin
                cs_n_d = CS_N_IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, request and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            is_wr_q  <= 1'b0;
            dir_q    <= 8'h00;
            wdata_q  <= 8'h00;
            dout_q   <= 8'h00;
            ad_out_q <= 8'h00;
            cs_n_q   <= CS_N_IDLE;
            rd_n_q   <= RD_N_IDLE;
            wr_n_q   <= WR_N_IDLE;
            rtc_ad_q <= AD_IDLE;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_wr_q  <= is_wr_d;
            dir_q    <= dir_d;
            wdata_q  <= wdata_d;
            dout_q   <= dout_d;
            ad_out_q <= ad_out_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            rtc_ad_q <= rtc_ad_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rtc_cs_n = cs_n_q;
    assign bus.rtc_rd_n = rd_n_q;
    assign bus.rtc_wr_n = wr_n_q;
    assign bus.rtc_ad   = rtc_ad_q;
    assign bus.ad_out   = ad_out_q;
    assign bus.ad_oe    = oe_q;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: a transaction vector table on a
// PHASE_CYCLES=10 instance plus hand sequences (lockout, reset, PHASE_CYCLES=1).
module tb_rtc_bus_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       act_v, ws_v, rs_v;
    logic [7:0] dir_v, din_v, adin_v;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rtc_bus_ctrl_if if10 ();
    rtc_bus_ctrl_if if1 ();

    assign if10.act_rtc      = act_v & ~sel;
    assign if10.write_strobe = ws_v;
    assign if10.read_strobe  = rs_v;
    assign if10.dir          = dir_v;
    assign if10.data_in      = din_v;
    assign if10.ad_in        = if10.rtc_rd_n ? 8'hEE : adin_v;
    assign if1.act_rtc       = act_v & sel;
    assign if1.write_strobe  = ws_v;
    assign if1.read_strobe   = rs_v;
    assign if1.dir           = dir_v;
    assign if1.data_in       = din_v;
    assign if1.ad_in         = if1.rtc_rd_n ? 8'hEE : adin_v;

    rtc_bus_ctrl #(.PHASE_CYCLES(10)) dut10 (.clk(clk), .reset(reset), .bus(if10.slave));
    rtc_bus_ctrl #(.PHASE_CYCLES(1))  dut1  (.clk(clk), .reset(reset), .bus(if1.slave));

    logic       m_cs, m_rd, m_wr, m_ad, m_oe, m_busy, m_done;
    logic [7:0] m_aout, m_dout;
    assign m_cs   = sel ? if1.rtc_cs_n : if10.rtc_cs_n;
    assign m_rd   = sel ? if1.rtc_rd_n : if10.rtc_rd_n;
    assign m_wr   = sel ? if1.rtc_wr_n : if10.rtc_wr_n;
    assign m_ad   = sel ? if1.rtc_ad   : if10.rtc_ad;
    assign m_oe   = sel ? if1.ad_oe    : if10.ad_oe;
    assign m_busy = sel ? if1.busy     : if10.busy;
    assign m_done = sel ? if1.done     : if10.done;
    assign m_aout = sel ? if1.ad_out   : if10.ad_out;
    assign m_dout = sel ? if1.data_out : if10.data_out;

    typedef struct {
        logic       act, ws, rs;
        logic [7:0] dir, din, adin;
        int         e_busy, e_done, e_wr, e_rd;
        logic [7:0] e_addr, e_wdata, e_dout, e_dprev;
    } vec_t;
    vec_t vecs[6];

    int         busy_n, done_n, wr_low, rd_low, conflict_n;
    logic [7:0] addr_seen, wdata_seen, dout_before, dout_at_rise;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic a, input logic w, input logic r,
                          input logic [7:0] d, input logic [7:0] di);
        @(negedge clk);
        act_v = a; ws_v = w; rs_v = r; dir_v = d; din_v = di;
        @(negedge clk);
        act_v = 1'b0; ws_v = 1'b0; rs_v = 1'b0;
    endtask

    // Samples win cycles; optionally re-issues a write strobe at sample poke_at.
    task automatic monitor(input int win, input int poke_at);
        logic prev_rd;
        prev_rd = 1'b1;
        busy_n = 0; done_n = 0; wr_low = 0; rd_low = 0; conflict_n = 0;
        addr_seen = 8'h00; wdata_seen = 8'h00; dout_before = 8'h00; dout_at_rise = 8'h00;
        for (int i = 0; i < win; i++) begin
            if (m_busy) busy_n++;
            if (m_done) done_n++;
            if (!m_wr) wr_low++;
            if (!m_rd) rd_low++;
            if (!m_rd && m_oe) conflict_n++;
            if (!m_wr && !m_ad && !m_cs) addr_seen = m_aout;
            if (!m_cs && m_ad && m_oe) wdata_seen = m_aout;
            if (!m_rd) dout_before = m_dout;
            if (!prev_rd && m_rd) dout_at_rise = m_dout;
            prev_rd = m_rd;
            if (i == poke_at) begin
                act_v = 1'b1; ws_v = 1'b1; dir_v = 8'h55; din_v = 8'hAA;
            end else begin
                act_v = 1'b0; ws_v = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    logic [5:0] trace_exp[10];
    bit         found;

    initial begin
        //         act   ws    rs    dir    din    adin   busy done wr rd addr  wdata  dout   dprev
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h21, 8'h59, 8'h00, 71, 1, 20, 0,  8'h21, 8'h59, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 8'h37, 71, 1, 10, 10, 8'h22, 8'h00, 8'h37, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h30, 8'hC3, 8'h99, 71, 1, 20, 0,  8'h30, 8'hC3, 8'h37, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h44, 8'h12, 8'h00, 0,  0, 0,  0,  8'h00, 8'h00, 8'h37, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h45, 8'h13, 8'h00, 0,  0, 0,  0,  8'h00, 8'h00, 8'h37, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h7F, 8'h00, 8'h5A, 71, 1, 10, 10, 8'h7F, 8'h00, 8'h5A, 8'h37};
        // {cs_n, wr_n, rtc_ad, ad_oe, busy, done} per cycle of a PHASE_CYCLES=1 write
        trace_exp[0] = 6'b010110; trace_exp[1] = 6'b000110; trace_exp[2] = 6'b010110;
        trace_exp[3] = 6'b111010; trace_exp[4] = 6'b011110; trace_exp[5] = 6'b001110;
        trace_exp[6] = 6'b011110; trace_exp[7] = 6'b111011; trace_exp[8] = 6'b111000;
        trace_exp[9] = 6'b111000;

        sel = 1'b0; act_v = 1'b0; ws_v = 1'b0; rs_v = 1'b0;
        dir_v = 8'h00; din_v = 8'h00; adin_v = 8'h00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bus", {m_cs, m_rd, m_wr, m_ad, m_oe}, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        chk("reset_status", {m_aout, m_dout, m_busy, m_done}, {8'h00, 8'h00, 1'b0, 1'b0});
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            adin_v = vecs[v].adin;
            launch(vecs[v].act, vecs[v].ws, vecs[v].rs, vecs[v].dir, vecs[v].din);
            monitor(80, -1);
            chk($sformatf("v%0d_busy", v), busy_n, vecs[v].e_busy);
            chk($sformatf("v%0d_done", v), done_n, vecs[v].e_done);
            chk($sformatf("v%0d_wr_low", v), wr_low, vecs[v].e_wr);
            chk($sformatf("v%0d_rd_low", v), rd_low, vecs[v].e_rd);
            chk($sformatf("v%0d_addr", v), addr_seen, vecs[v].e_addr);
            chk($sformatf("v%0d_wdata", v), wdata_seen, vecs[v].e_wdata);
            chk($sformatf("v%0d_dout", v), m_dout, vecs[v].e_dout);
            chk($sformatf("v%0d_oe_rd", v), conflict_n, 0);
            if (vecs[v].e_rd != 0) begin
                chk($sformatf("v%0d_dout_last_strobe", v), dout_before, vecs[v].e_dprev);
                chk($sformatf("v%0d_dout_after_strobe", v), dout_at_rise, vecs[v].adin);
            end
        end

        // Busy lockout: second write strobe during the address phase is dropped
        launch(1'b1, 1'b1, 1'b0, 8'h11, 8'h66);
        monitor(80, 4);
        chk("lock_done", done_n, 1);
        chk("lock_busy", busy_n, 71);
        chk("lock_wr_low", wr_low, 20);
        chk("lock_addr", addr_seen, 8'h11);
        chk("lock_wdata", wdata_seen, 8'h66);

        // Reset asserted in the middle of DATA_STROBE of a write
        launch(1'b1, 1'b1, 1'b0, 8'h48, 8'h9C);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!m_cs && m_ad && !m_wr) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_wait_strobe", found, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_bus", {m_cs, m_rd, m_wr, m_ad, m_oe}, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        chk("rst_mid_status", {m_aout, m_dout, m_busy, m_done}, {8'h00, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        launch(1'b1, 1'b1, 1'b0, 8'h21, 8'h59);
        monitor(80, -1);
        chk("post_rst_done", done_n, 1);
        chk("post_rst_busy", busy_n, 71);
        chk("post_rst_addr", addr_seen, 8'h21);
        chk("post_rst_wdata", wdata_seen, 8'h59);

        // PHASE_CYCLES=1 instance: one-cycle phases, busy for 8 cycles
        @(negedge clk);
        sel = 1'b1;
        launch(1'b1, 1'b1, 1'b0, 8'h21, 8'h59);
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_busy) busy_n++;
            chk($sformatf("p1_trace%0d", i), {m_cs, m_wr, m_ad, m_oe, m_busy, m_done}, trace_exp[i]);
            if (i == 1) chk("p1_addr", m_aout, 8'h21);
            if (i == 5) chk("p1_wdata", m_aout, 8'h59);
            @(negedge clk);
        end
        chk("p1_busy", busy_n, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle generator between the PicoBlaze port decoder and the external real-time-clock chip's multiplexed address/data bus. It consumes the decoder's RTC select, strobes, register address and output byte. It replays each access as a timed two-phase cycle on the RTC bus: an address phase, then a data phase. Read data is returned on the byte feeding the RTC input-port mux.

## Interface
- PHASE_CYCLES, 10: clk cycles per bus phase; legal range ≥ 1; 10 gives 100 ns at 100 MHz.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- act_rtc  in  1  RTC port select from the port decoder.
- write_strobe  in  1  combined write/k-write strobe from the micro.
- read_strobe  in  1  read strobe from the micro.
- dir  in  8  RTC register address from the decoder.
- data_in  in  8  micro out_port byte.
- data_out  out  8  last byte captured from the RTC; drives the RTC input-port line.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when a transaction completes.
- rtc_cs_n, rtc_rd_n, rtc_wr_n  out  1 each  active-low chip select, read and write.
- rtc_ad  out  1  bus qualifier: 0 = address phase, 1 = data phase.
- ad_out  out  8  bus drive value.
- ad_oe  out  1  bus drive enable; the top-level IOBUF uses it.
- ad_in  in  8  bus sample.

## Operation
- FSM states: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, GAP, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE.
- Every state except IDLE and DONE lasts exactly PHASE_CYCLES cycles. DONE lasts 1 cycle.
- Accept condition: in IDLE, act_rtc=1 and (write_strobe or read_strobe).
  - On accept, latch the type, dir and data_in.
  - If both strobes are high, the transaction is a write.
  - Strobes arriving in any state other than IDLE are ignored. They are not queued.
- Address phase (ADDR_*):
  - rtc_cs_n=0, rtc_ad=0, ad_oe=1, ad_out=latched dir.
  - rtc_wr_n=0 only during ADDR_STROBE.
- GAP: rtc_cs_n=1, ad_oe=0, all strobes high.
- Write data phase (DATA_*):
  - rtc_cs_n=0, rtc_ad=1, ad_oe=1, ad_out=latched data_in.
  - rtc_wr_n=0 during DATA_STROBE.
- Read data phase (DATA_*):
  - rtc_cs_n=0, rtc_ad=1, ad_oe=0.
  - rtc_rd_n=0 during DATA_STROBE.
  - ad_in is registered into data_out on the last cycle of DATA_STROBE.
- DONE: done=1, bus idle, then return to IDLE.
- data_out changes only on a read capture and otherwise holds its value.
- Firmware read pattern:
  1. INPUT launches the bus read.
  2. Poll busy (exported at top level through a status port).
  3. A second INPUT returns the captured byte. That INPUT also launches a harmless read.
- Never drive the bus while rtc_rd_n=0: ad_oe=0 whenever rtc_rd_n=0.

## Timing
- Reset values, applied immediately when reset falls (including mid-transaction):
  - rtc_cs_n=rtc_rd_n=rtc_wr_n=1, rtc_ad=1, ad_oe=0, ad_out=0.
  - data_out=0, busy=0, done=0, state=IDLE.
- Accept happens on edge N. busy=1 from N+1 through the DONE cycle inclusive, i.e. 7·PHASE_CYCLES+1 cycles.
- Output timing: all bus outputs are registered and change on state entry. There are no combinational paths from inputs to outputs.
- Strobe pulse: rtc_wr_n/rtc_rd_n pulses are PHASE_CYCLES wide. Each is preceded and followed by PHASE_CYCLES of stable address/data setup and hold.
- Next accept: earliest is the cycle after DONE, when the FSM is back in IDLE.
- Phase counter:
  - Width $clog2(PHASE_CYCLES+1).
  - Loads PHASE_CYCLES-1 on state entry, decrements, and advances the state at 0.
  - PHASE_CYCLES=1 yields one-cycle phases.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state enum;
  - the bus idle constants (CS/RD/WR high, AD=1);
  - the default PHASE_CYCLES.
- One sub-module, rtc_phase_timer: a loadable down-counter with a terminal-count output, instantiated once.

## Test plan
- Write: act_rtc=1, write_strobe pulse, dir=0x21, data_in=0x59 (PHASE_CYCLES=10).
  - Address phase: ad_out=0x21, 10-cycle rtc_wr_n low.
  - Data phase: ad_out=0x59 with rtc_ad=1.
  - done after 71 busy cycles.
- Read: read_strobe, dir=0x22, model drives ad_in=0x37 while rtc_rd_n=0.
  - ad_oe=0 throughout the data phase.
  - data_out=0x37 from the cycle after DATA_STROBE ends.
- Busy lockout: second write_strobe issued 5 cycles after accept → ignored; exactly one bus transaction observed.
- Simultaneous strobes: write_strobe=read_strobe=1 with act_rtc=1 → write cycle. act_rtc=0 with either strobe → no activity.
- Reset mid DATA_STROBE: reset low → all outputs at reset values in the same cycle. After release, a new write completes normally.
- PHASE_CYCLES=1: write completes with busy high for exactly 8 cycles and every phase 1 cycle long.
